// File: rtl/ddr3_pkg.sv
// Shared DDR3 definitions: command codes, per-beat address step and the
// write/read scheduler FSM encoding.
package ddr3_pkg;

    localparam logic [2:0] WRITE_CMD = 3'b000;
    localparam logic [2:0] READ_CMD  = 3'b001;

    // Address increment per 128-bit beat; must match the MIG burst engine.
    localparam int ADDR_STEP = 16;

    // Cycles a request may wait for the engine to raise busy before re-issue.
    localparam int WAIT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RUN  = 3'd3,
        ST_UPD  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/ddr3_wr_ctrl.sv
// Write-burst scheduler in front of the DDR3 MIG write-burst engine.
// Issues one start/len/addr request per burst once the write FIFO holds
// enough beats, advances the address per burst, wraps at frame end and
// ping-pongs between two frame banks.
//
// Handshake: wr_burst_start is a 1-cycle request; len/addr are held from
// start until the engine's wr_burst_done. The request counts as accepted
// when wr_burst_busy is seen high; otherwise it is re-issued after
// WAIT_TIMEOUT cycles with identical len/addr. wr_burst_done is only
// honoured while a burst is running.
module ddr3_wr_ctrl
    import ddr3_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 28,
    parameter int                    CNT_WIDTH   = 10,
    parameter int                    BURST_LEN   = 64,
    parameter int                    FRAME_BEATS = 259200,
    parameter int                    STEP        = ddr3_pkg::ADDR_STEP,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] BANK_OFFSET = ADDR_WIDTH'(28'h0800000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  frame_sync,
    input  logic [CNT_WIDTH-1:0]  fifo_rd_count,
    output logic                  wr_burst_start,
    output logic [ADDR_WIDTH-1:0] wr_burst_len,
    output logic [ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                  wr_burst_busy,
    input  logic                  wr_burst_done,
    output logic                  frame_done,
    output logic                  bank_sel,
    output ctrl_state_t           state_dbg
);

    localparam int MAX_BL  = (FRAME_BEATS > BURST_LEN) ? FRAME_BEATS : BURST_LEN;
    localparam int BL_W    = $clog2(MAX_BL + 1);
    localparam int CMP_W   = (BL_W > CNT_WIDTH) ? BL_W : CNT_WIDTH;
    localparam int STEP_SH = $clog2(STEP);

    localparam logic [BL_W-1:0] FRAME_BL = BL_W'(FRAME_BEATS);
    localparam logic [BL_W-1:0] BURST_BL = BL_W'(BURST_LEN);

    ctrl_state_t           state_q, state_d;
    logic [BL_W-1:0]       beat_left_q, beat_left_d;
    logic                  sync_pend_q, sync_pend_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  start_q, start_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  frame_done_q, frame_done_d;
    logic                  bank_q, bank_d;

    logic [BL_W-1:0]       cur_len;
    logic [BL_W-1:0]       beat_after;
    logic                  fifo_ready;

    function automatic logic [ADDR_WIDTH-1:0] bank_base(input logic b);
        return b ? (BASE_ADDR + BANK_OFFSET) : BASE_ADDR;
    endfunction

    // Burst length and FIFO threshold; the final burst of a frame may be short.
    always_comb begin
        cur_len    = (beat_left_q < BURST_BL) ? beat_left_q : BURST_BL;
        beat_after = beat_left_q - BL_W'(len_q);
        fifo_ready = CMP_W'(fifo_rd_count) >= CMP_W'(cur_len);
    end

    // Next-state logic: FSM transitions plus address/bank/frame bookkeeping.
    always_comb begin
        state_d      = state_q;
        beat_left_d  = beat_left_q;
        sync_pend_d  = sync_pend_q;
        wait_cnt_d   = wait_cnt_q;
        start_d      = 1'b0;
        len_d        = len_q;
        addr_d       = addr_q;
        frame_done_d = 1'b0;
        bank_d       = bank_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_sync) begin
                    addr_d      = bank_base(bank_q);
                    beat_left_d = FRAME_BL;
                end
                if (enable && !wr_burst_busy) state_d = ST_ARM;
            end
            ST_ARM: begin
                // A frame restart takes this cycle; the request follows with the new base.
                if (frame_sync) begin
                    addr_d      = bank_base(bank_q);
                    beat_left_d = FRAME_BL;
                end
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (!frame_sync && fifo_ready) begin
                    start_d    = 1'b1;
                    len_d      = ADDR_WIDTH'(cur_len);
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (frame_sync) sync_pend_d = 1'b1;
                if (wr_burst_busy) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == 4'(WAIT_TIMEOUT - 1)) begin
                    state_d = ST_ARM;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (frame_sync) sync_pend_d = 1'b1;
                if (wr_burst_done) state_d = ST_UPD;
            end
            ST_UPD: begin
                if (beat_after == '0) begin
                    // Natural frame end wins over any pending restart.
                    frame_done_d = 1'b1;
                    bank_d       = ~bank_q;
                    addr_d       = bank_base(~bank_q);
                    beat_left_d  = FRAME_BL;
                end else if (sync_pend_q || frame_sync) begin
                    addr_d      = bank_base(bank_q);
                    beat_left_d = FRAME_BL;
                end else begin
                    addr_d      = addr_q + (len_q << STEP_SH);
                    beat_left_d = beat_after;
                end
                sync_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_left_q  <= FRAME_BL;
            sync_pend_q  <= 1'b0;
            wait_cnt_q   <= '0;
            start_q      <= 1'b0;
            len_q        <= '0;
            addr_q       <= BASE_ADDR;
            frame_done_q <= 1'b0;
            bank_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_left_q  <= beat_left_d;
            sync_pend_q  <= sync_pend_d;
            wait_cnt_q   <= wait_cnt_d;
            start_q      <= start_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            frame_done_q <= frame_done_d;
            bank_q       <= bank_d;
        end
    end

    assign wr_burst_start = start_q;
    assign wr_burst_len   = len_q;
    assign wr_burst_addr  = addr_q;
    assign frame_done     = frame_done_q;
    assign bank_sel       = bank_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_ddr3_wr_ctrl.sv
// Bench for ddr3_wr_ctrl: a small frame (200 beats) so wraps, short final
// bursts and bank toggles happen quickly. The reference model tracks the
// frame as plain numbers: beats remaining, next address, current bank.
module tb_ddr3_wr_ctrl;
    import ddr3_pkg::*;

    localparam int          AW   = 28;
    localparam int          CW   = 10;
    localparam int          BL   = 64;
    localparam int          FB   = 200;
    localparam int          STP  = 16;
    localparam logic [27:0] BASE = 28'h0;
    localparam logic [27:0] OFF  = 28'h0800000;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          frame_sync;
    logic [CW-1:0] fifo_rd_count;
    logic          wr_burst_start;
    logic [AW-1:0] wr_burst_len;
    logic [AW-1:0] wr_burst_addr;
    logic          wr_burst_busy;
    logic          wr_burst_done;
    logic          frame_done;
    logic          bank_sel;
    ctrl_state_t   state_dbg;

    ddr3_wr_ctrl #(
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .BURST_LEN  (BL),
        .FRAME_BEATS(FB),
        .STEP       (STP),
        .BASE_ADDR  (BASE),
        .BANK_OFFSET(OFF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .frame_sync    (frame_sync),
        .fifo_rd_count (fifo_rd_count),
        .wr_burst_start(wr_burst_start),
        .wr_burst_len  (wr_burst_len),
        .wr_burst_addr (wr_burst_addr),
        .wr_burst_busy (wr_burst_busy),
        .wr_burst_done (wr_burst_done),
        .frame_done    (frame_done),
        .bank_sel      (bank_sel),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [55:0] exp_q[$];   // {len, addr} of the next expected request

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_beat;
    logic [27:0] m_addr;
    bit          m_bank;

    function automatic logic [27:0] base_of(input bit b);
        return b ? (BASE + OFF) : BASE;
    endfunction

    function automatic int model_len();
        return (m_beat < BL) ? m_beat : BL;
    endfunction

    task automatic model_reset();
        m_beat = FB;
        m_addr = BASE;
        m_bank = 1'b0;
    endtask

    // Outcome of a completed burst; sync means a restart arrived during it.
    task automatic model_done(input bit sync, output bit fd);
        int len;
        len = model_len();
        fd  = 1'b0;
        if (m_beat - len == 0) begin
            m_bank = ~m_bank;
            m_addr = base_of(m_bank);
            m_beat = FB;
            fd     = 1'b1;
        end else if (sync) begin
            m_addr = base_of(m_bank);
            m_beat = FB;
        end else begin
            m_beat = m_beat - len;
            m_addr = m_addr + 28'(len * STP);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_start(input int max_cyc, output bit got, output int n);
        got = 1'b0;
        n   = 0;
        while (!got && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (wr_burst_start) got = 1'b1;
        end
    endtask

    task automatic expect_start(input int max_cyc, output bit got);
        logic [55:0] e;
        int n;
        exp_q.push_back({28'(model_len()), m_addr});
        wait_start(max_cyc, got, n);
        e = exp_q.pop_front();
        check_eq("start_seen", 32'(got), 32'd1);
        if (got) begin
            check_eq("burst_len", 32'(wr_burst_len), 32'(e[55:28]));
            check_eq("burst_addr", 32'(wr_burst_addr), 32'(e[27:0]));
        end
    endtask

    // Engine model: accept the request seen at this negedge, run, finish.
    task automatic engine_run(input int busy_cyc, input bit sync_run, input bit drop_en);
        bit fd;
        wr_burst_busy = 1'b1;
        @(negedge clk);
        check_eq("start_pulse", 32'(wr_burst_start), 32'd0);
        for (int i = 0; i < busy_cyc; i++) begin
            if (i == 0 && sync_run) frame_sync = 1'b1;
            if (i == 0 && drop_en) enable = 1'b0;
            @(negedge clk);
            frame_sync = 1'b0;
        end
        check_eq("len_hold", 32'(wr_burst_len), 32'(model_len()));
        check_eq("addr_hold", 32'(wr_burst_addr), 32'(m_addr));
        wr_burst_done = 1'b1;
        @(negedge clk);
        wr_burst_done = 1'b0;
        wr_burst_busy = 1'b0;
        @(negedge clk);
        model_done(sync_run, fd);
        check_eq("next_addr", 32'(wr_burst_addr), 32'(m_addr));
        check_eq("bank_sel", 32'(bank_sel), 32'(m_bank));
        check_eq("frame_done", 32'(frame_done), 32'(fd));
    endtask

    task automatic burst(input bit sync_run);
        bit got;
        fifo_rd_count = CW'($urandom_range(1023, model_len()));
        expect_start(40, got);
        if (got) engine_run($urandom_range(1, 6), sync_run, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit got;
        int n;

        rst = 1'b1; enable = 1'b0; frame_sync = 1'b0; fifo_rd_count = '0;
        wr_burst_busy = 1'b0; wr_burst_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_start", 32'(wr_burst_start), 32'd0);
        check_eq("rst_len", 32'(wr_burst_len), 32'd0);
        check_eq("rst_addr", 32'(wr_burst_addr), 32'(BASE));
        check_eq("rst_fd", 32'(frame_done), 32'd0);
        check_eq("rst_bank", 32'(bank_sel), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;

        // Threshold: 63 beats is not enough for a 64-beat burst.
        enable = 1'b1;
        fifo_rd_count = 10'd63;
        wait_start(20, got, n);
        check_eq("no_start_63", 32'(got), 32'd0);
        fifo_rd_count = 10'd64;
        expect_start(10, got);
        if (got) engine_run(3, 1'b0, 1'b0);
        check_eq("t1_addr_1024", 32'(wr_burst_addr), 32'd1024);

        // Restart during the burst at 2048: back to bank base, no frame_done.
        burst(1'b0);
        check_eq("t3_pre_addr", 32'(wr_burst_addr), 32'd2048);
        burst(1'b1);
        check_eq("t3_addr_base", 32'(wr_burst_addr), 32'(BASE));

        // Full 200-beat frame: 64,64,64,8 then bank toggle.
        for (int i = 0; i < 4; i++) burst(1'b0);
        check_eq("t2_bank", 32'(bank_sel), 32'd1);
        check_eq("t2_addr", 32'(wr_burst_addr), 32'(OFF));

        // Engine never answers: identical request re-issued after the timeout.
        fifo_rd_count = 10'd1023;
        expect_start(20, got);
        if (got) begin
            wait_start(30, got, n);
            check_eq("reissue_seen", 32'(got), 32'd1);
            check_eq("reissue_gap_ok", 32'(n >= 15 && n <= 18), 32'd1);
            check_eq("reissue_len", 32'(wr_burst_len), 32'(model_len()));
            check_eq("reissue_addr", 32'(wr_burst_addr), 32'(m_addr));
            // Enable dropped mid-burst: it completes, then nothing new starts.
            if (got) engine_run(3, 1'b0, 1'b1);
        end
        wait_start(30, got, n);
        check_eq("no_start_disabled", 32'(got), 32'd0);
        enable = 1'b1;
        burst(1'b0);

        // Randomized traffic with occasional restarts between and during bursts.
        for (int r = 0; r < 25; r++) begin
            fifo_rd_count = '0;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                frame_sync = 1'b1;
                @(negedge clk);
                frame_sync = 1'b0;
                m_addr = base_of(m_bank);
                m_beat = FB;
            end
            burst($urandom_range(0, 4) == 0);
        end

        // Reset in the middle of a running burst.
        fifo_rd_count = 10'd1023;
        expect_start(40, got);
        wr_burst_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_start", 32'(wr_burst_start), 32'd0);
        check_eq("mid_rst_len", 32'(wr_burst_len), 32'd0);
        check_eq("mid_rst_addr", 32'(wr_burst_addr), 32'(BASE));
        check_eq("mid_rst_fd", 32'(frame_done), 32'd0);
        check_eq("mid_rst_bank", 32'(bank_sel), 32'd0);
        rst = 1'b0;
        wr_burst_busy = 1'b0;
        model_reset();
        burst(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
